// File: rtl/dmux4way_buffered.sv
// Four-lane demultiplexer with a one-entry holding register per lane and valid/ready handshakes.
// Optional per-lane delivery counters are enabled by defining DMUX4WAY_BUFFERED_COUNT_EN.
module dmux4way_buffered #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic [WIDTH-1:0] outD,
    output logic             validA,
    output logic             validB,
    output logic             validC,
    output logic             validD,
    input  logic             readyA,
    input  logic             readyB,
    input  logic             readyC,
    input  logic             readyD
`ifdef DMUX4WAY_BUFFERED_COUNT_EN
    ,
    output logic [7:0]       countA,
    output logic [7:0]       countB,
    output logic [7:0]       countC,
    output logic [7:0]       countD
`endif
);

    typedef enum logic {LaneEmpty, LaneFull} laneState_t;

    laneState_t       laneState [4];
    logic [WIDTH-1:0] laneData  [4];
    logic [3:0]       laneReady;
    logic             inXfer;

    assign laneReady = {readyD, readyC, readyB, readyA};

    // A full lane can still accept when its consumer drains it in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (laneState[select] == LaneEmpty) || laneReady[select];
        end
    end

    assign inXfer = in_valid && in_ready;

`ifdef DMUX4WAY_BUFFERED_COUNT_EN
    logic [7:0] laneCount [4];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                laneState[i] <= LaneEmpty;
                laneData[i]  <= '0;
`ifdef DMUX4WAY_BUFFERED_COUNT_EN
                laneCount[i] <= 8'd0;
`endif
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                unique case (laneState[i])
                    LaneEmpty: begin
                        if (inXfer && (select == 2'(i))) begin
                            laneState[i] <= LaneFull;
                            laneData[i]  <= in;
                        end
                    end
                    LaneFull: begin
                        // Simultaneous drain and load keeps the lane full with no bubble.
                        if (inXfer && (select == 2'(i))) begin
                            laneData[i] <= in;
                        end else if (laneReady[i]) begin
                            laneState[i] <= LaneEmpty;
                        end
                    end
                    default: laneState[i] <= LaneEmpty;
                endcase
`ifdef DMUX4WAY_BUFFERED_COUNT_EN
                if ((laneState[i] == LaneFull) && laneReady[i]) begin
                    laneCount[i] <= laneCount[i] + 8'd1;
                end
`endif
            end
        end
    end

    assign outA   = laneData[0];
    assign outB   = laneData[1];
    assign outC   = laneData[2];
    assign outD   = laneData[3];
    assign validA = (laneState[0] == LaneFull);
    assign validB = (laneState[1] == LaneFull);
    assign validC = (laneState[2] == LaneFull);
    assign validD = (laneState[3] == LaneFull);

`ifdef DMUX4WAY_BUFFERED_COUNT_EN
    assign countA = laneCount[0];
    assign countB = laneCount[1];
    assign countC = laneCount[2];
    assign countD = laneCount[3];
`endif

endmodule

// File: tb/tb_dmux4way_buffered.sv
// Bench for dmux4way_buffered: directed vector table, a lane-ordering scoreboard run,
// and counter checks when DMUX4WAY_BUFFERED_COUNT_EN is defined.
module tb_dmux4way_buffered;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic [1:0]   select;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] outA, outB, outC, outD;
    logic         validA, validB, validC, validD;
    logic         readyA, readyB, readyC, readyD;
`ifdef DMUX4WAY_BUFFERED_COUNT_EN
    logic [7:0]   countA, countB, countC, countD;
`endif

    int vectors = 0;
    int errors  = 0;

    dmux4way_buffered #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .select   (select),
        .in_valid (inValid),
        .in_ready (inReady),
        .outA     (outA),
        .outB     (outB),
        .outC     (outC),
        .outD     (outD),
        .validA   (validA),
        .validB   (validB),
        .validC   (validC),
        .validD   (validD),
        .readyA   (readyA),
        .readyB   (readyB),
        .readyC   (readyC),
        .readyD   (readyD)
`ifdef DMUX4WAY_BUFFERED_COUNT_EN
        ,
        .countA   (countA),
        .countB   (countB),
        .countC   (countC),
        .countD   (countD)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ready/valid/out vectors are packed {D, C, B, A}.
    typedef struct {
        logic         rst;
        logic [W-1:0] din;
        logic [1:0]   sel;
        logic         v;
        logic [3:0]   rdy;
        logic         expReady;
        logic [3:0]   expValid;
        logic [31:0]  expOut;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic [W-1:0] d, input logic [1:0] s,
                         input logic v, input logic [3:0] rdy);
        reset   = r;
        din     = d;
        select  = s;
        inValid = v;
        {readyD, readyC, readyB, readyA} = rdy;
    endtask

    initial begin
        logic [W-1:0] q [$];
        logic         modelFull;
        logic [W-1:0] nextWord;
        logic [W-1:0] expWord;
        int           sent;
        int           got;
        int           cyc;
        logic         acc;
        logic         del;

        drive(1'b1, '0, 2'd0, 1'b0, 4'b0000);

        tbl[0]  = '{1'b1, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000, 32'h00_00_00_00};
        tbl[1]  = '{1'b0, 8'h01, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00_01_00_00};
        tbl[2]  = '{1'b0, 8'h00, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0100, 32'h00_01_00_00};
        tbl[3]  = '{1'b0, 8'h00, 2'd0, 1'b0, 4'b0100, 1'b1, 4'b0000, 32'h00_01_00_00};
        tbl[4]  = '{1'b0, 8'h11, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h00_01_11_00};
        tbl[5]  = '{1'b0, 8'h22, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h00_01_11_00};
        tbl[6]  = '{1'b0, 8'h22, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h00_01_22_00};
        tbl[7]  = '{1'b0, 8'h00, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 32'h00_01_22_00};
        tbl[8]  = '{1'b0, 8'h00, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h00_01_22_00};
        tbl[9]  = '{1'b0, 8'h01, 2'd0, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h00_01_22_01};
        tbl[10] = '{1'b0, 8'h0B, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h00_01_0B_01};
        tbl[11] = '{1'b0, 8'h0C, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h00_0C_0B_01};
        tbl[12] = '{1'b0, 8'h0D, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'h0D_0C_0B_01};
        tbl[13] = '{1'b0, 8'h55, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h0D_0C_0B_01};
        tbl[14] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0D_0C_0B_01};
        tbl[15] = '{1'b0, 8'h42, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h0D_0C_42_01};
        tbl[16] = '{1'b0, 8'h44, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1010, 32'h44_0C_42_01};
        tbl[17] = '{1'b1, 8'h77, 2'd0, 1'b1, 4'b1111, 1'b0, 4'b0000, 32'h00_00_00_00};
        tbl[18] = '{1'b0, 8'h99, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1000, 32'h99_00_00_00};
        tbl[19] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'b1000, 1'b1, 4'b0000, 32'h99_00_00_00};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].din, tbl[i].sel, tbl[i].v, tbl[i].rdy);
            #1;
            check("in_ready", i, {31'd0, inReady}, {31'd0, tbl[i].expReady});
            @(posedge clk);
            #1;
            check("valid", i, {28'd0, validD, validC, validB, validA}, {28'd0, tbl[i].expValid});
            check("out", i, {outD, outC, outB, outA}, tbl[i].expOut);
        end

        // Lane A ordering under irregular backpressure, scoreboarded against a queue.
        modelFull = 1'b0;
        sent = 0;
        got = 0;
        nextWord = 8'hA0;
        for (cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            drive(1'b0, nextWord, 2'd0, sent < 8, {3'b000, ((cyc % 3) != 1)});
            #1;
            check("seq_in_ready", cyc, {31'd0, inReady}, {31'd0, !modelFull || readyA});
            acc = inValid && inReady;
            del = validA && readyA;
            if (del) begin
                expWord = q.pop_front();
                check("seq_order", got, {24'd0, outA}, {24'd0, expWord});
                got++;
            end
            if (acc) begin
                q.push_back(nextWord);
                nextWord = nextWord + 8'd1;
                sent++;
            end
            @(posedge clk);
            if (acc) modelFull = 1'b1;
            else if (del) modelFull = 1'b0;
        end
        check("seq_delivered", 0, got, 8);
        @(negedge clk);
        drive(1'b0, '0, 2'd0, 1'b0, 4'b0000);

`ifdef DMUX4WAY_BUFFERED_COUNT_EN
        @(negedge clk);
        drive(1'b1, '0, 2'd0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        check("cnt_reset", 0, {countD, countC, countB, countA}, 32'd0);
        for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            drive(1'b0, 8'(l + 1), 2'(l), 1'b1, 4'b0000);
        end
        @(negedge clk);
        drive(1'b0, '0, 2'd0, 1'b0, 4'b1111);
        @(posedge clk);
        #1;
        check("cnt_all", 0, {countD, countC, countB, countA}, 32'h01_01_01_01);
        check("cnt_valid", 0, {28'd0, validD, validC, validB, validA}, 32'd0);
        // 255 more deliveries on D: 254 pass-through cycles plus a final drain.
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            drive(1'b0, 8'(k), 2'd3, 1'b1, 4'b1000);
        end
        @(negedge clk);
        drive(1'b0, '0, 2'd3, 1'b0, 4'b1000);
        @(posedge clk);
        #1;
        check("cnt_wrap", 0, {24'd0, countD}, 32'd0);
        check("cnt_wrap_valid", 0, {31'd0, validD}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dmux4way_buffered.md
DMUX4WAY_BUFFERED -- requirements
Module: dmux4way_buffered

Interface
REQ-001 Parameter: WIDTH, default 1, data width of the input word and of each output lane.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in  input  WIDTH  data word to be routed.
REQ-005 select  input  2  destination lane: 00=A, 01=B, 10=C, 11=D.
REQ-006 in_valid  input  1  in and select are valid this cycle.
REQ-007 in_ready  output  1  block accepts the presented word this cycle.
REQ-008 outA/outB/outC/outD  output  WIDTH each  per-lane registered data.
REQ-009 validA/validB/validC/validD  output  1 each  lane holds an undelivered word.
REQ-010 readyA/readyB/readyC/readyD  input  1 each  lane consumer takes the word this cycle.

Function
REQ-011 Each lane SHALL own a one-entry holding register with two states: EMPTY (valid=0) and FULL (valid=1).
REQ-012 An input transfer SHALL occur on a cycle when in_valid=1 and in_ready=1, and an output transfer on lane X when validX=1 and readyX=1.
REQ-013 in_ready SHALL be combinational: it is 1 when the lane addressed by select is EMPTY, or FULL with its ready high in the same cycle. It SHALL NOT depend on in_valid.
REQ-014 On an input transfer, the addressed lane SHALL load in into outX and go FULL on the next edge, giving one cycle of latency from acceptance to validX=1.
REQ-015 Lanes not addressed by select SHALL be unaffected by an input transfer.
REQ-016 On an output transfer with no simultaneous input transfer to the same lane, the lane SHALL go EMPTY. outX SHALL hold its last value.
REQ-017 On a simultaneous output and input transfer on the same lane, the lane SHALL stay FULL and load the new word. The old word counts as delivered and no bubble is inserted.
REQ-018 While FULL with readyX=0, outX and validX SHALL remain stable.
REQ-019 Up to four lanes SHALL drain independently in the same cycle, and one input transfer SHALL be possible per cycle.
REQ-020 Words SHALL never be dropped or duplicated. The order of delivery within a lane SHALL equal the order of acceptance.
REQ-021 If in_valid=1 and the addressed lane is blocked, the block SHALL hold in_ready=0. Input data SHALL NOT be captured.

Reset
REQ-022 While reset=1 at a clock edge, every lane SHALL go EMPTY, validA..D=0, outA..D=0, and all counters (if present) SHALL be 0.
REQ-023 While reset=1, in_ready SHALL be 0 and no transfer SHALL be recorded.
REQ-024 A reset asserted mid-operation SHALL discard any held words. Operation SHALL resume on the first edge with reset=0.

Configuration
REQ-025 With macro DMUX4WAY_BUFFERED_COUNT_EN defined, the block SHALL add outputs countA..countD (8 bits each).
REQ-026 With the macro defined, each counter SHALL increment by 1 on every output transfer of its lane and wrap from 255 to 0.
REQ-027 Without the macro, those ports and registers SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-028 Basic routing: reset, then in=1, select=10, in_valid=1 for one cycle. Required: next cycle validC=1 and outC=1, with validA/B/D=0.
REQ-029 Backpressure: load lane B with readyB=0, then present a second word to B. Required: in_ready=0, outB holds the first word; after readyB=1, the first word is delivered and the second is accepted the same cycle.
REQ-030 Pass-through: lane A FULL with word 0, readyA=1, new word 1 to select=00. Required: in_ready=1, validA stays 1, outA=1 next cycle, with no EMPTY cycle.
REQ-031 Independence: lanes A–D all FULL, all ready=1 in one cycle. Required: all validX=0 next cycle; with COUNT_EN, each countX increments by 1.
REQ-032 Reset mid-operation: lanes B and D FULL, reset=1 for one cycle. Required: all validX=0, outX=0, in_ready=0 during reset, and counts=0.
REQ-033 Counter wrap (COUNT_EN only): 256 deliveries on lane D. Required: countD returns to 0.
